// File: rtl/median_pkg.sv
// median_pkg
// Shared types and constants for the 5x5 median-filter window controller.
// Holds the controller state enum, kernel/line-buffer geometry and the
// default counter widths used by median_window_ctrl and its bench.
package median_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int KSIZE_C   = 5;     // kernel edge length
    localparam int NUM_LB    = 4;     // line buffers rotated per line
    localparam int AW_DEF    = 11;    // column / address counter width
    localparam int RW_DEF    = 11;    // row counter width
    localparam int MAX_W_DEF = 2048;  // deepest supported line

    // A window touches the top/left image edge while the newest pixel
    // is within KSIZE-1 columns/rows of the start of line/frame.
    localparam int BORDER_OFS = KSIZE_C - 1;

endpackage

// File: rtl/sync_delay.sv
// sync_delay
// Fixed-depth shift register with synchronous clear. Used to delay the
// video sync/DE bits so they line up with a pipelined pixel datapath.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high clear of every stage
//   d_i  - WIDTH-bit input sampled each clock
//   q_o  - d_i delayed by DEPTH clocks
module sync_delay #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/median_window_ctrl.sv
// median_window_ctrl
// Sequencing controller for the 5x5 median datapath. Learns the active
// line width from the first line after vsync, then drives the 4-line
// buffer (write strobe, shared address, row rotation), flags valid and
// border windows, and delays dv/hs/vs to match the datapath latency.
// Ports:
//   clk, rst          - pixel clock, synchronous active-high reset
//   rx_dv/rx_hs/rx_vs - video timing from the receiver
//   lb_wr_en, lb_addr - line-buffer write strobe and shared address
//   lb_wr_sel         - line buffer written on the current line (0..3)
//   win_valid, border - window populated / window touches top-left edge
//   line_width        - measured width, 0 while not locked
//   locked            - controller in RUN
//   tx_dv/tx_hs/tx_vs - rx_* delayed by PIPE_LAT cycles
//   err_cnt           - saturating count of width failures
//   dbg_state_o       - current controller state
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int MAX_W    = MAX_W_DEF,
    parameter int AW       = AW_DEF,
    parameter int RW       = RW_DEF,
    parameter int PIPE_LAT = 6,
    parameter int KSIZE    = KSIZE_C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_dv,
    input  logic          rx_hs,
    input  logic          rx_vs,
    output logic          lb_wr_en,
    output logic [AW-1:0] lb_addr,
    output logic [1:0]    lb_wr_sel,
    output logic          win_valid,
    output logic          border,
    output logic [AW:0]   line_width,
    output logic          locked,
    output logic          tx_dv,
    output logic          tx_hs,
    output logic          tx_vs,
    output logic [7:0]    err_cnt,
    output state_e        dbg_state_o
);

    state_e          state_q, state_d;
    logic            dv_q, vs_q;
    logic [AW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d, pix_row;
    logic [1:0]      sel_q, sel_d;
    logic [AW:0]     width_q, width_d, width_chk;
    logic [7:0]      err_q, err_d;
    logic            wr_en_q, wr_en_d;
    logic            win_q, win_d;
    logic            border_q, border_d;
    logic            vs_rise, dv_fall, dv_rise, err_inc;

    always_comb begin
        vs_rise   = rx_vs & ~vs_q;
        dv_fall   = ~rx_dv & dv_q;
        dv_rise   = rx_dv & ~dv_q;
        // Pixel count of the line that is ending on dv_fall.
        width_chk = {1'b0, col_q} + {{AW{1'b0}}, 1'b1};

        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        sel_d    = sel_q;
        width_d  = width_q;
        err_inc  = 1'b0;

        // Column of the pixel sampled this cycle; vsync also restarts it.
        if (vs_rise) begin
            col_d = '0;
        end
        if (rx_dv) begin
            col_d = (dv_rise | vs_rise) ? '0 : col_q + AW'(1);
        end

        // vs_rise takes priority over a coincident dv_fall.
        if (vs_rise) begin
            row_d = '0;
            sel_d = '0;
        end else if (dv_fall) begin
            if (row_q != {RW{1'b1}}) begin
                row_d = row_q + RW'(1);
            end
            sel_d = sel_q + 2'd1;  // 2 bits wrap through the NUM_LB buffers
        end

        unique case (state_q)
            ST_SEARCH: begin
                if (vs_rise) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (vs_rise) begin
                    state_d = ST_MEASURE;
                end else if (dv_fall) begin
                    width_d = width_chk;
                    state_d = ST_RUN;
                end else if (rx_dv && dv_q && col_q == AW'(MAX_W - 1)) begin
                    // Line continues past MAX_W pixels: cannot be buffered.
                    err_inc = 1'b1;
                    state_d = ST_SEARCH;
                end
            end
            ST_RUN: begin
                if (!vs_rise && dv_fall && width_chk != width_q) begin
                    err_inc = 1'b1;
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase

        if (state_d == ST_SEARCH) begin
            width_d = '0;
        end

        err_d = err_q;
        if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end

        // Row of the pixel sampled this cycle.
        pix_row  = vs_rise ? '0 : row_q;
        wr_en_d  = rx_dv & (state_q != ST_SEARCH);
        win_d    = rx_dv & (state_q == ST_RUN);
        // Only top/left edges are flagged: the output image is shifted
        // by two pixels/lines, so right/bottom windows are always full.
        border_d = win_d & ((col_d < AW'(BORDER_OFS)) | (pix_row < RW'(BORDER_OFS)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            dv_q     <= 1'b0;
            vs_q     <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            sel_q    <= '0;
            width_q  <= '0;
            err_q    <= '0;
            wr_en_q  <= 1'b0;
            win_q    <= 1'b0;
            border_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dv_q     <= rx_dv;
            vs_q     <= rx_vs;
            col_q    <= col_d;
            row_q    <= row_d;
            sel_q    <= sel_d;
            width_q  <= width_d;
            err_q    <= err_d;
            wr_en_q  <= wr_en_d;
            win_q    <= win_d;
            border_q <= border_d;
        end
    end

    sync_delay #(
        .DEPTH (PIPE_LAT),
        .WIDTH (3)
    ) u_sync_delay (
        .clk (clk),
        .rst (rst),
        .d_i ({rx_dv, rx_hs, rx_vs}),
        .q_o ({tx_dv, tx_hs, tx_vs})
    );

    assign lb_wr_en    = wr_en_q;
    assign lb_addr     = col_q;
    assign lb_wr_sel   = sel_q;
    assign win_valid   = win_q;
    assign border      = border_q;
    assign line_width  = width_q;
    assign locked      = (state_q == ST_RUN);
    assign err_cnt     = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_median_window_ctrl.sv
module tb_median_window_ctrl;
    import median_pkg::*;

    localparam int AW       = 11;
    localparam int RW       = 11;
    localparam int PIPE_LAT = 6;
    localparam int W        = 16;
    localparam int LINES    = 8;

    logic          clk = 1'b0;
    logic          rst, rx_dv, rx_hs, rx_vs;
    logic          lb_wr_en, win_valid, border, locked;
    logic          tx_dv, tx_hs, tx_vs;
    logic [AW-1:0] lb_addr;
    logic [1:0]    lb_wr_sel;
    logic [AW:0]   line_width;
    logic [7:0]    err_cnt;
    state_e        dbg_state;

    median_window_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rx_dv       (rx_dv),
        .rx_hs       (rx_hs),
        .rx_vs       (rx_vs),
        .lb_wr_en    (lb_wr_en),
        .lb_addr     (lb_addr),
        .lb_wr_sel   (lb_wr_sel),
        .win_valid   (win_valid),
        .border      (border),
        .line_width  (line_width),
        .locked      (locked),
        .tx_dv       (tx_dv),
        .tx_hs       (tx_hs),
        .tx_vs       (tx_vs),
        .err_cnt     (err_cnt),
        .dbg_state_o (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame/line level view of the controller.
    bit         m_locked, m_meas;
    int         m_width, m_err, m_row, m_sel;
    logic [2:0] exp_q[$];  // {dv,hs,vs} as seen PIPE_LAT samples ago at exp_q[0]

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_meas = 0; m_width = 0; m_err = 0; m_row = 0; m_sel = 0;
    endtask

    task automatic model_vs();
        m_row = 0;
        m_sel = 0;
        if (!m_locked) m_meas = 1;
    endtask

    task automatic model_line_end(input int n);
        if (m_meas) begin
            m_width = n; m_meas = 0; m_locked = 1;
        end else if (m_locked && n != m_width) begin
            if (m_err < 255) m_err++;
            m_locked = 0; m_width = 0;
        end
        if (m_row < (1 << RW) - 1) m_row++;
        m_sel = (m_sel + 1) % NUM_LB;
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, and the
    // delayed sync bits are checked every cycle against the history queue.
    task automatic tick();
        logic [2:0] s;
        logic       r;
        s = {rx_dv, rx_hs, rx_vs};
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            for (int i = 0; i < PIPE_LAT; i++) exp_q.push_back(3'b000);
        end else begin
            exp_q.push_back(s);
            void'(exp_q.pop_front());
        end
        chk("tx_dv", 32'(tx_dv), 32'(exp_q[0][2]));
        chk("tx_hs", 32'(tx_hs), 32'(exp_q[0][1]));
        chk("tx_vs", 32'(tx_vs), 32'(exp_q[0][0]));
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
        chk({tag, "_width"},  32'(line_width), 32'(m_width));
        chk({tag, "_err"},    32'(err_cnt), 32'(m_err));
        chk({tag, "_sel"},    32'(lb_wr_sel), 32'(m_sel));
    endtask

    task automatic pixels(input int n);
        for (int x = 0; x < n; x++) begin
            rx_dv = 1'b1;
            tick();
            chk("wr_en",  32'(lb_wr_en), 32'(m_locked || m_meas));
            chk("addr",   32'(lb_addr), 32'(x));
            chk("win",    32'(win_valid), 32'(m_locked));
            chk("border", 32'(border), 32'(m_locked && (x < 4 || m_row < 4)));
        end
    endtask

    // Horizontal blank after the dv_fall cycle, with one hsync pulse.
    task automatic blank();
        int hb, p;
        hb = $urandom_range(4, 7);
        p  = $urandom_range(1, hb - 2);
        for (int i = 1; i < hb; i++) begin
            rx_hs = (i == p);
            tick();
        end
        rx_hs = 1'b0;
    endtask

    task automatic do_line(input int n);
        pixels(n);
        rx_dv = 1'b0;
        tick();
        model_line_end(n);
        chk_status("line_end");
        blank();
    endtask

    task automatic do_vsync();
        rx_vs = 1'b1;
        tick();
        model_vs();
        chk_status("vsync");
        repeat ($urandom_range(0, 2)) tick();
        rx_vs = 1'b0;
        repeat (2) tick();
    endtask

    task automatic do_frame(input int glitch_at);
        do_vsync();
        for (int l = 0; l < LINES; l++) do_line((l == glitch_at) ? W - 1 : W);
        repeat (3) tick();
    endtask

    initial begin
        // reset
        rst = 1'b1; rx_dv = 1'b0; rx_hs = 1'b0; rx_vs = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_wr_en", 32'(lb_wr_en), 32'd0);
        chk("rst_addr",  32'(lb_addr), 32'd0);
        chk("rst_win",   32'(win_valid), 32'd0);
        chk("rst_border",32'(border), 32'd0);
        chk_status("rst");
        rst = 1'b0;
        repeat (2) tick();

        // Three clean frames: lock after first line, width 16
        repeat (3) do_frame(-1);
        chk("locked_after_frames", 32'(locked), 32'd1);
        chk("width_after_frames",  32'(line_width), 32'(W));

        // Width glitch on line 3, then relock on the next frame
        do_frame(3);
        chk("glitch_err",    32'(err_cnt), 32'd1);
        chk("glitch_locked", 32'(locked), 32'd0);
        do_frame(-1);
        chk("relock_width",  32'(line_width), 32'(W));

        // Simultaneous vs_rise and dv_fall on a short line: no width check
        do_vsync();
        do_line(W);
        do_line(W);
        pixels(W - 1);
        rx_dv = 1'b0;
        rx_vs = 1'b1;
        tick();
        model_vs();
        chk_status("vs_dv_fall");
        rx_vs = 1'b0;
        blank();
        for (int l = 0; l < 5; l++) do_line(W);
        repeat (3) tick();

        // Reset in the middle of a RUN line
        pixels(6);
        rst = 1'b1;
        tick();
        model_reset();
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_width",  32'(line_width), 32'd0);
        chk("midrst_wr_en",  32'(lb_wr_en), 32'd0);
        chk("midrst_err",    32'(err_cnt), 32'd0);
        rst = 1'b0;
        repeat (W - 6) tick();
        rx_dv = 1'b0;
        tick();
        blank();
        repeat (3) tick();
        do_frame(-1);
        chk("final_locked", 32'(locked), 32'd1);
        chk("final_width",  32'(line_width), 32'(W));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
